// File: rtl/diag_led_driver_pkg.sv
// -----------------------------------------------------------------------------
// CKRSPkg -- shared types for the diagnostic LED driver.
//
// Contents:
//   led_mode_t  per-channel LED mode (2 bits): LED_OFF, LED_ON, LED_BLINK,
//               LED_ACTIVITY.
//   cnt_width() counter width for a 0..n-1 range, never less than one bit.
// -----------------------------------------------------------------------------
package CKRSPkg;

    typedef enum logic [1:0] {
        LED_OFF      = 2'd0,
        LED_ON       = 2'd1,
        LED_BLINK    = 2'd2,
        LED_ACTIVITY = 2'd3
    } led_mode_t;

    // $clog2 returns 0 for a range of one value; a zero-width counter is not
    // legal, so the result is clamped to one bit.
    function automatic int unsigned cnt_width(input int unsigned range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/diag_led_driver_channel.sv
// -----------------------------------------------------------------------------
// led_activity_channel -- activity-stretch FSM for one LED channel.
//
// A single event lights the LED for STRETCH_TICKS ticks, followed by a dark
// gap of STRETCH_TICKS ticks. Events seen while lit or in the gap collapse into
// one pending flag, giving at most one further flash after the gap.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   tick_i    in   timebase tick (one cycle wide)
//   enable_i  in   channel is in LED_ACTIVITY mode; low forces idle
//   event_i   in   activity strobe, one event per high cycle
//   on_o      out  LED should be lit (taken from the next state)
// -----------------------------------------------------------------------------
module led_activity_channel
    import CKRSPkg::*;
#(
    parameter int unsigned STRETCH_TICKS = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic enable_i,
    input  logic event_i,
    output logic on_o
);

    localparam int unsigned CNT_W = $clog2(STRETCH_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRETCH_TICKS);

    typedef logic [1:0] act_state_t;
    localparam act_state_t ACT_IDLE = 2'd0;
    localparam act_state_t ACT_ON   = 2'd1;
    localparam act_state_t ACT_GAP  = 2'd2;

    if (STRETCH_TICKS < 1) begin : g_bad_stretch
        $error("led_activity_channel: STRETCH_TICKS must be >= 1");
    end

    act_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             pend_q, pend_d;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        if (!enable_i) begin
            state_d = ACT_IDLE;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ACT_IDLE: begin
                    if (event_i) begin
                        state_d = ACT_ON;
                        cnt_d   = '0;
                    end
                end
                ACT_ON: begin
                    // An event on the same cycle as the closing tick is kept:
                    // the move to the gap and the pending flag both happen.
                    if (event_i) pend_d = 1'b1;
                    if (tick_i) begin
                        if (cnt_inc == CNT_LAST) begin
                            state_d = ACT_GAP;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                ACT_GAP: begin
                    if (event_i) pend_d = 1'b1;
                    if (tick_i && (cnt_inc == CNT_LAST)) begin
                        // An event on the closing tick counts as pending.
                        state_d = (pend_q || event_i) ? ACT_ON : ACT_IDLE;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                    end else if (tick_i) begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ACT_IDLE;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACT_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Driven from the next state so that, after the LED output register in the
    // parent, the LED lights on the cycle right after the triggering event.
    assign on_o = (state_d == ACT_ON);

endmodule

// File: rtl/diag_led_driver.sv
// -----------------------------------------------------------------------------
// diag_led_driver -- multi-channel diagnostic LED driver.
//
// A prescaler derives a TICK_HZ timebase from clk. A shared blink counter
// toggles one blink phase every BLINK_TICKS ticks so every blinking channel is
// in phase. Each channel selects off / on / blink / activity-stretch, and the
// result is registered (optionally inverted) onto led_o.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   mode_i   in   NUM_LEDS x led_mode_t, per-channel mode
//   event_i  in   NUM_LEDS activity strobes
//   tick_o   out  one-cycle timebase tick
//   led_o    out  NUM_LEDS registered LED drive, inverted when ACTIVE_LOW=1
// -----------------------------------------------------------------------------
module diag_led_driver
    import CKRSPkg::*;
#(
    parameter int unsigned NUM_LEDS      = 3,
    parameter int unsigned CLK_HZ        = 100000000,
    parameter int unsigned TICK_HZ       = 1000,
    parameter int unsigned BLINK_TICKS   = 100,
    parameter int unsigned STRETCH_TICKS = 50,
    parameter bit          ACTIVE_LOW    = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  led_mode_t [NUM_LEDS-1:0] mode_i,
    input  logic      [NUM_LEDS-1:0] event_i,
    output logic                     tick_o,
    output logic      [NUM_LEDS-1:0] led_o
);

    localparam int unsigned TICK_SAFE = (TICK_HZ == 0) ? 1 : TICK_HZ;
    localparam int unsigned DIV       = CLK_HZ / TICK_SAFE;
    localparam int unsigned PRE_W     = cnt_width(DIV);
    localparam int unsigned BLK_W     = cnt_width(BLINK_TICKS);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

    if (NUM_LEDS < 1 || NUM_LEDS > 16) begin : g_bad_num
        $error("diag_led_driver: NUM_LEDS must be 1..16");
    end
    if (TICK_HZ == 0 || DIV < 1 || (CLK_HZ % TICK_SAFE) != 0) begin : g_bad_tick
        $error("diag_led_driver: CLK_HZ must be a non-zero multiple of TICK_HZ");
    end
    if (BLINK_TICKS < 1) begin : g_bad_blink
        $error("diag_led_driver: BLINK_TICKS must be >= 1");
    end
    if (STRETCH_TICKS < 1) begin : g_bad_stretch
        $error("diag_led_driver: STRETCH_TICKS must be >= 1");
    end

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [BLK_W-1:0]    blk_q, blk_d;
    logic                phase_q, phase_d;
    logic                tick_w;
    logic [NUM_LEDS-1:0] act_on;
    logic [NUM_LEDS-1:0] led_lv;
    logic [NUM_LEDS-1:0] led_q, led_d;

    // Gated by rst so a divide-by-one timebase stays quiet during reset.
    assign tick_w = (pre_q == PRE_LAST) && !rst;
    assign tick_o = tick_w;

    always_comb begin
        pre_d   = tick_w ? '0 : pre_q + PRE_W'(1);
        blk_d   = blk_q;
        phase_d = phase_q;
        if (tick_w) begin
            if (blk_q == BLK_LAST) begin
                blk_d   = '0;
                phase_d = ~phase_q;
            end else begin
                blk_d = blk_q + BLK_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        led_activity_channel #(
            .STRETCH_TICKS (STRETCH_TICKS)
        ) u_act (
            .clk      (clk),
            .rst      (rst),
            .tick_i   (tick_w),
            .enable_i (mode_i[g] == LED_ACTIVITY),
            .event_i  (event_i[g]),
            .on_o     (act_on[g])
        );
    end

    // Blink uses the next phase so the LED follows the wrap tick by one cycle,
    // matching the activity channels' next-state timing.
    always_comb begin
        led_lv = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (mode_i[i])
                LED_OFF:      led_lv[i] = 1'b0;
                LED_ON:       led_lv[i] = 1'b1;
                LED_BLINK:    led_lv[i] = phase_d;
                LED_ACTIVITY: led_lv[i] = act_on[i];
                default:      led_lv[i] = 1'b0;
            endcase
        end
        led_d = led_lv ^ {NUM_LEDS{ACTIVE_LOW}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            blk_q   <= '0;
            phase_q <= 1'b0;
            led_q   <= {NUM_LEDS{ACTIVE_LOW}};
        end else begin
            pre_q   <= pre_d;
            blk_q   <= blk_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: tb/tb_diag_led_driver.sv
// -----------------------------------------------------------------------------
// tb_diag_led_driver -- directed scoreboard bench for diag_led_driver.
//
// Two instances share all inputs: one active-high, one active-low. The
// stimulus process walks a cycle timeline, drives inputs and pushes the
// hand-computed expected led_o/tick_o for a cycle into a queue; a monitor on
// the falling edge pops each entry on its cycle and compares both instances.
// Timebase: CLK_HZ/TICK_HZ = 10, BLINK_TICKS = 3, STRETCH_TICKS = 2.
// The last reset edge is cycle 5, so ticks fall on cycles 14, 24, 34, ...
// -----------------------------------------------------------------------------
module tb_diag_led_driver;
    import CKRSPkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    led_mode_t [2:0] mode;
    logic      [2:0] ev = 3'b000;
    logic            tick0, tick1;
    logic      [2:0] led0, led1;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [2:0] led;
        logic       tick;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    diag_led_driver #(
        .NUM_LEDS      (3),
        .CLK_HZ        (1000),
        .TICK_HZ       (100),
        .BLINK_TICKS   (3),
        .STRETCH_TICKS (2),
        .ACTIVE_LOW    (1'b0)
    ) u_dut_hi (
        .clk     (clk),
        .rst     (rst),
        .mode_i  (mode),
        .event_i (ev),
        .tick_o  (tick0),
        .led_o   (led0)
    );

    diag_led_driver #(
        .NUM_LEDS      (3),
        .CLK_HZ        (1000),
        .TICK_HZ       (100),
        .BLINK_TICKS   (3),
        .STRETCH_TICKS (2),
        .ACTIVE_LOW    (1'b1)
    ) u_dut_lo (
        .clk     (clk),
        .rst     (rst),
        .mode_i  (mode),
        .event_i (ev),
        .tick_o  (tick1),
        .led_o   (led1)
    );

    // Monitor: compare every due scoreboard entry on the falling edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            if (mon_e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_entry cyc=%0d now=%0d", mon_e.cyc, cyc);
            end else begin
                checks++;
                if (led0 !== mon_e.led) begin
                    errors++;
                    $display("FAIL led_hi cyc=%0d actual=%b required=%b", cyc, led0, mon_e.led);
                end
                checks++;
                if (led1 !== ~mon_e.led) begin
                    errors++;
                    $display("FAIL led_lo cyc=%0d actual=%b required=%b", cyc, led1, ~mon_e.led);
                end
                checks++;
                if (tick0 !== mon_e.tick || tick1 !== mon_e.tick) begin
                    errors++;
                    $display("FAIL tick cyc=%0d actual=%b/%b required=%b", cyc, tick0, tick1, mon_e.tick);
                end
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
            ev = 3'b000;
        end
    endtask

    task automatic at(input int c, input logic [2:0] led, input logic tick);
        exp_t e;
        goto(c);
        e.cyc  = cyc;
        e.led  = led;
        e.tick = tick;
        sb_q.push_back(e);
    endtask

    task automatic pulse2(input int c);
        goto(c);
        ev[2] = 1'b1;
    endtask

    task automatic set_modes(input led_mode_t m2, input led_mode_t m1, input led_mode_t m0);
        mode[2] = m2;
        mode[1] = m1;
        mode[0] = m0;
    endtask

    initial begin
        set_modes(LED_OFF, LED_OFF, LED_OFF);
        rst = 1'b1;

        // Reset state, then release; all channels off.
        at(5, 3'b000, 1'b0);
        rst = 1'b0;
        at(6, 3'b000, 1'b0);
        at(13, 3'b000, 1'b0);
        at(14, 3'b000, 1'b1);
        at(15, 3'b000, 1'b0);
        at(24, 3'b000, 1'b1);

        // ch0/ch1 blink in phase, ch2 steady on.
        at(25, 3'b000, 1'b0);
        set_modes(LED_ON, LED_BLINK, LED_BLINK);
        at(26, 3'b100, 1'b0);
        at(34, 3'b100, 1'b1);
        at(35, 3'b111, 1'b0);
        at(44, 3'b111, 1'b1);
        at(64, 3'b111, 1'b1);
        at(65, 3'b100, 1'b0);

        // ch2 activity: single event, flash for two ticks, gap for two ticks.
        at(66, 3'b100, 1'b0);
        set_modes(LED_ACTIVITY, LED_OFF, LED_OFF);
        at(67, 3'b000, 1'b0);
        at(70, 3'b000, 1'b0);
        ev[2] = 1'b1;
        at(71, 3'b100, 1'b0);
        at(84, 3'b100, 1'b1);
        at(85, 3'b000, 1'b0);
        at(104, 3'b000, 1'b1);
        at(105, 3'b000, 1'b0);

        // Five events during on+gap collapse into one further flash.
        pulse2(110);
        at(111, 3'b100, 1'b0);
        pulse2(112);
        pulse2(118);
        at(124, 3'b100, 1'b1);
        at(125, 3'b000, 1'b0);
        pulse2(128);
        pulse2(136);
        pulse2(140);
        at(144, 3'b000, 1'b1);
        at(145, 3'b100, 1'b0);
        at(164, 3'b100, 1'b1);
        at(165, 3'b000, 1'b0);
        at(185, 3'b000, 1'b0);

        // Mode off mid-flash with pending set; events while off are ignored.
        pulse2(190);
        at(191, 3'b100, 1'b0);
        pulse2(192);
        at(196, 3'b100, 1'b0);
        set_modes(LED_OFF, LED_OFF, LED_OFF);
        at(197, 3'b000, 1'b0);
        pulse2(198);
        goto(200);
        set_modes(LED_ACTIVITY, LED_OFF, LED_OFF);
        at(201, 3'b000, 1'b0);
        at(210, 3'b000, 1'b0);
        at(225, 3'b000, 1'b0);

        // Event on the closing tick of the on phase is still honoured.
        pulse2(230);
        at(231, 3'b100, 1'b0);
        at(244, 3'b100, 1'b1);
        ev[2] = 1'b1;
        at(245, 3'b000, 1'b0);
        at(265, 3'b100, 1'b0);

        // Reset mid-flash; prescaler restarts from the last reset edge (273).
        at(270, 3'b100, 1'b0);
        rst = 1'b1;
        at(271, 3'b000, 1'b0);
        goto(273);
        rst = 1'b0;
        at(274, 3'b000, 1'b0);
        at(281, 3'b000, 1'b0);
        at(282, 3'b000, 1'b1);
        at(283, 3'b000, 1'b0);

        goto(290);
        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/diag_led_driver.md
DIAG_LED_DRIVER -- requirements
Module: diag_led_driver

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 3, number of independent LED channels (1..16).
REQ-002 SHALL have parameter CLK_HZ, default 100000000, clk frequency in Hz.
REQ-003 SHALL have parameter TICK_HZ, default 1000, timebase tick rate; CLK_HZ mod TICK_HZ != 0 is an elaboration error.
REQ-004 SHALL have parameter BLINK_TICKS, default 100, blink half-period in ticks (>=1, else elaboration error).
REQ-005 SHALL have parameter STRETCH_TICKS, default 50, activity on-time and off-gap in ticks (>=1, else elaboration error).
REQ-006 SHALL have parameter ACTIVE_LOW, default 0, 1 inverts every led_o bit.
REQ-007 clk  input  1  single clock for all logic; one clock; reset is synchronous and active-high.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 mode_i  input  NUM_LEDS x led_mode_t (2 bits)  per-channel mode: LED_OFF=0, LED_ON=1, LED_BLINK=2, LED_ACTIVITY=3.
REQ-010 event_i  input  NUM_LEDS  per-channel activity strobe, sampled every clk, level held high counts as one event per cycle.
REQ-011 tick_o  output  1  one-cycle timebase tick pulse.
REQ-012 led_o  output  NUM_LEDS  registered LED drive, polarity per ACTIVE_LOW.

Function
REQ-013 Prescaler SHALL count 0..CLK_HZ/TICK_HZ-1, width $clog2 of that range, and pulse tick_o in the cycle the count equals terminal value, wrapping to 0.
REQ-014 Blink counter SHALL advance on tick_o, count 0..BLINK_TICKS-1, and toggle a shared blink_phase (reset 0) on the tick where it wraps; all LED_BLINK channels SHALL be in phase.
REQ-015 Logical LED value per channel: LED_OFF->0, LED_ON->1, LED_BLINK->blink_phase, LED_ACTIVITY->1 only in state ACT_ON.
REQ-016 led_o SHALL be registered: logical value computed in cycle N appears on led_o in cycle N+1, XOR ACTIVE_LOW.
REQ-017 Activity FSM per channel SHALL have states ACT_IDLE, ACT_ON, ACT_GAP plus a pending flag and a stretch counter of width $clog2(STRETCH_TICKS+1).
REQ-018 ACT_IDLE: event_i=1 and mode LED_ACTIVITY -> ACT_ON, counter cleared.
REQ-019 ACT_ON: counter increments on tick_o; on the tick bringing it to STRETCH_TICKS -> ACT_GAP, counter cleared; events here set pending.
REQ-020 ACT_GAP: counter increments on tick_o; on tick reaching STRETCH_TICKS -> ACT_ON if pending (or event_i that cycle), pending cleared, else ACT_IDLE; events here set pending.
REQ-021 Any number of events during one ACT_ON+ACT_GAP window SHALL collapse into a single further flash.
REQ-022 Mode other than LED_ACTIVITY SHALL force FSM to ACT_IDLE, clear pending and counter in the next cycle; events are ignored.
REQ-023 Mode changes SHALL take effect on led_o one cycle after mode_i changes; blink counter and prescaler SHALL never be reset by mode changes.
REQ-024 Simultaneous tick_o and event_i in ACT_ON SHALL both be honoured (transition plus pending set).

Reset
REQ-025 While rst=1: prescaler, blink counter, blink_phase, all stretch counters and pending flags 0; all FSMs ACT_IDLE; tick_o 0; led_o = {NUM_LEDS{ACTIVE_LOW}}.
REQ-026 rst asserted mid-flash SHALL drive led_o inactive in the cycle after rst is sampled; first tick_o SHALL occur CLK_HZ/TICK_HZ cycles after rst deasserts.

Structure
REQ-027 led_mode_t and its four enumerators SHALL live in the shared package CKRSPkg; act_state_t stays local to the sub-module.
REQ-028 Per-channel activity FSM SHALL be sub-module led_activity_channel (ports clk, rst, tick_i, enable_i, event_i, on_o), instantiated NUM_LEDS times by generate; prescaler and blink counter stay in diag_led_driver.

Verification (CLK_HZ=1000, TICK_HZ=100, BLINK_TICKS=3, STRETCH_TICKS=2, NUM_LEDS=3)
REQ-029 Reset release, all modes LED_OFF -> led_o=000 throughout, tick_o first high exactly 10 cycles after release, then every 10 cycles.
REQ-030 ch0 and ch1 LED_BLINK -> both bits identical, toggling every 30 cycles, first rise on cycle after 3rd tick; ch2 LED_ON -> led_o[2]=1 one cycle after mode set.
REQ-031 ch2 LED_ACTIVITY, single event_i[2] pulse in IDLE -> led_o[2]=1 next cycle, falls cycle after 2nd tick, stays 0 for 2 ticks, FSM returns IDLE.
REQ-032 Five events during ACT_ON and ACT_GAP -> exactly one further flash starting cycle after gap end, then IDLE.
REQ-033 ch2 mode LED_ACTIVITY->LED_OFF mid ACT_ON with pending set -> led_o[2]=0 next cycle, return to LED_ACTIVITY shows no flash without new event; rst mid-flash -> led_o=000 next cycle.
REQ-034 ACTIVE_LOW=1 rerun of REQ-029/031 -> led_o bitwise inverted (reset value 111).
